// File: rtl/grid_cursor_ctrl_if.sv
// Cursor bus: key/button/enable inputs toward the controller and the cursor
// position outputs back. Widths follow the grid dimensions.
interface grid_cursor_ctrl_if #(
  parameter int COLS = 6,
  parameter int ROWS = 6
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int PW = $clog2(ROWS * COLS);

  logic [3:0]    keys;
  logic          A;
  logic          enable;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [PW-1:0] pos;
  logic          moved;
  logic          select;

  modport master (
    output keys, A, enable,
    input  row, col, pos, moved, select
  );

  modport slave (
    input  keys, A, enable,
    output row, col, pos, moved, select
  );
endinterface

// File: rtl/grid_cursor_ctrl.sv
// Grid cursor controller with press / hold / auto-repeat key handling and a
// select pulse. Define CURSOR_WRAP_EN to wrap at grid edges instead of clamping.
module grid_cursor_ctrl #(
  parameter int COLS         = 6,
  parameter int ROWS         = 6,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 4
) (
  input  logic               clock,
  input  logic               reset,
  grid_cursor_ctrl_if.slave  bus
);
  localparam int RW      = $clog2(ROWS);
  localparam int CW      = $clog2(COLS);
  localparam int PW      = $clog2(ROWS * COLS);
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNTW    = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

  state_t          state_q;
  logic [CNTW-1:0] cnt_q;
  logic [3:0]      keys_q;
  logic [3:0]      key_last_q;
  logic            A_q;
  logic            A_prev_q;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic [PW-1:0]   pos_q, pos_d;
  logic            moved_q;
  logic            select_q;

  logic key_valid;
  logic same_key;
  logic press_new;
  logic repeat_due;
  logic do_move;

  function automatic int step_dec(input int v, input int n);
`ifdef CURSOR_WRAP_EN
    return (v == 0) ? n - 1 : v - 1;
`else
    return (v == 0) ? 0 : v - 1;
`endif
  endfunction

  function automatic int step_inc(input int v, input int n);
`ifdef CURSOR_WRAP_EN
    return (v == n - 1) ? 0 : v + 1;
`else
    return (v == n - 1) ? n - 1 : v + 1;
`endif
  endfunction

  // Direction decode and move target from the registered key copy
  always_comb begin
    key_valid = (keys_q != 4'd0) && ((keys_q & (keys_q - 4'd1)) == 4'd0);
    same_key  = (keys_q == key_last_q);
    row_d     = row_q;
    col_d     = col_q;
    case (keys_q)
      4'b0001: row_d = RW'(step_dec(int'(row_q), ROWS));
      4'b0010: row_d = RW'(step_inc(int'(row_q), ROWS));
      4'b0100: col_d = CW'(step_dec(int'(col_q), COLS));
      4'b1000: col_d = CW'(step_inc(int'(col_q), COLS));
      default: ;
    endcase
    pos_d      = PW'(int'(row_d) * COLS + int'(col_d));
    press_new  = key_valid && ((state_q == IDLE) || !same_key);
    repeat_due = key_valid && same_key &&
                 (((state_q == HOLD)   && (cnt_q == CNTW'(REPEAT_DELAY - 1))) ||
                  ((state_q == REPEAT) && (cnt_q == CNTW'(REPEAT_RATE - 1))));
    do_move    = bus.enable && (press_new || repeat_due);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      keys_q     <= '0;
      key_last_q <= '0;
      A_q        <= 1'b0;
      A_prev_q   <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      pos_q      <= '0;
      moved_q    <= 1'b0;
      select_q   <= 1'b0;
    end else begin
      keys_q   <= bus.keys;
      A_q      <= bus.A;
      A_prev_q <= A_q;
      moved_q  <= 1'b0;
      select_q <= 1'b0;
      if (!bus.enable) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        select_q <= A_q & ~A_prev_q;
        case (state_q)
          IDLE: begin
            if (key_valid) begin
              state_q    <= HOLD;
              cnt_q      <= '0;
              key_last_q <= keys_q;
            end
          end
          HOLD, REPEAT: begin
            if (!key_valid) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else if (!same_key) begin
              state_q    <= HOLD;
              cnt_q      <= '0;
              key_last_q <= keys_q;
            end else if (repeat_due) begin
              state_q <= REPEAT;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNTW'(1);
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
        // A clamped move keeps the FSM timing but leaves position and moved alone
        if (do_move) begin
          row_q   <= row_d;
          col_q   <= col_d;
          pos_q   <= pos_d;
          moved_q <= (row_d != row_q) || (col_d != col_q);
        end
      end
    end
  end

  assign bus.row    = row_q;
  assign bus.col    = col_q;
  assign bus.pos    = pos_q;
  assign bus.moved  = moved_q;
  assign bus.select = select_q;
endmodule

// File: tb/tb_grid_cursor_ctrl.sv
// Scoreboard bench for grid_cursor_ctrl: directed scenarios plus random key
// traffic, checked every cycle against a hold-age based reference model.
module tb_grid_cursor_ctrl;
  localparam int COLS = 6;
  localparam int ROWS = 6;
  localparam int DLY  = 8;
  localparam int RATE = 4;

  typedef struct {
    int row;
    int col;
    int pos;
    bit moved;
    bit select;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  grid_cursor_ctrl_if #(.COLS(COLS), .ROWS(ROWS)) bus ();

  grid_cursor_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  exp_t sb[$];
  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;
  bit   started = 0;

  // Reference state: registered input copies plus how long the current key has been held
  int         m_row = 0, m_col = 0;
  logic [3:0] m_kq = 0, m_key = 0;
  bit         m_aq = 0, m_aprev = 0;
  int         age = -1;

  task automatic model_edge(input logic [3:0] k, input bit a, input bit en, input bit r);
    exp_t e;
    bit   want = 0, mv = 0, sel = 0;
    int   nr, nc;
    if (r) begin
      m_row = 0; m_col = 0; m_kq = 0; m_key = 0;
      m_aq = 0; m_aprev = 0; age = -1;
    end else begin
      sel = en && m_aq && !m_aprev;
      if (!en) age = -1;
      else if ($countones(m_kq) != 1) age = -1;
      else if (age < 0 || m_kq != m_key) begin
        age = 0; m_key = m_kq; want = 1;
      end else begin
        age++;
        want = (age == DLY) || (age > DLY && ((age - DLY) % RATE) == 0);
      end
      if (want) begin
        nr = m_row; nc = m_col;
        if (m_kq == 4'b0001) nr--;
        if (m_kq == 4'b0010) nr++;
        if (m_kq == 4'b0100) nc--;
        if (m_kq == 4'b1000) nc++;
`ifdef CURSOR_WRAP_EN
        nr = (nr + ROWS) % ROWS;
        nc = (nc + COLS) % COLS;
`else
        if (nr < 0) nr = 0;
        if (nr > ROWS - 1) nr = ROWS - 1;
        if (nc < 0) nc = 0;
        if (nc > COLS - 1) nc = COLS - 1;
`endif
        mv = (nr != m_row) || (nc != m_col);
        m_row = nr; m_col = nc;
      end
      m_aprev = m_aq; m_aq = a; m_kq = k;
    end
    e.row = m_row; e.col = m_col; e.pos = m_row * COLS + m_col;
    e.moved = mv; e.select = sel;
    sb.push_back(e);
  endtask

  task automatic step(input logic [3:0] k, input bit a, input bit en, input bit r);
    @(negedge clk);
    bus.keys = k; bus.A = a; bus.enable = en; rst = r;
    model_edge(k, a, en, r);
    started = 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic hold(input logic [3:0] k, input int n);
    for (int i = 0; i < n; i++) step(k, 1'b0, 1'b1, 1'b0);
  endtask

  // Monitor: one expected entry per active edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (int'(bus.row) != e.row || int'(bus.col) != e.col || int'(bus.pos) != e.pos ||
            bus.moved != e.moved || bus.select != e.select) begin
          errors++;
          $display("FAIL cursor cyc=%0d got row=%0d col=%0d pos=%0d moved=%0b select=%0b want row=%0d col=%0d pos=%0d moved=%0b select=%0b",
                   cyc, bus.row, bus.col, bus.pos, bus.moved, bus.select,
                   e.row, e.col, e.pos, e.moved, e.select);
        end
      end else if (started) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow cyc=%0d got empty queue want an entry", cyc);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] k;
    int         hold_n;
    int         r;
    bit         a;
    bus.keys = 4'd0; bus.A = 1'b0; bus.enable = 1'b1;

    // Reset then a single right tap
    step(4'd0, 1'b0, 1'b1, 1'b1);
    step(4'd0, 1'b0, 1'b1, 1'b1);
    step(4'b1000, 1'b0, 1'b1, 1'b0);
    idle(6);

    // Right held 20 cycles from origin
    step(4'd0, 1'b0, 1'b1, 1'b1);
    hold(4'b1000, 20);
    idle(4);

    // Walk to (2,0) then push left against the edge
    step(4'd0, 1'b0, 1'b1, 1'b1);
    hold(4'b0010, 1); idle(3);
    hold(4'b0010, 1); idle(3);
    hold(4'b0100, 1); idle(3);

    // Two keys at once, then A held
    hold(4'b1001, 10);
    for (int i = 0; i < 5; i++) step(4'd0, 1'b1, 1'b1, 1'b0);
    idle(3);

    // Enable drop mid-hold, re-enable, then reset mid-repeat with key still held
    step(4'd0, 1'b0, 1'b1, 1'b1);
    hold(4'b0010, 3);
    for (int i = 0; i < 15; i++) step(4'b0010, 1'b0, 1'b0, 1'b0);
    step(4'd0, 1'b0, 1'b1, 1'b1);
    hold(4'b1000, 14);
    step(4'b1000, 1'b0, 1'b1, 1'b1);
    hold(4'b1000, 6);
    idle(3);

    // Random traffic
    k = 4'd0; hold_n = 0; a = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold_n == 0) begin
        r = $urandom_range(0, 9);
        if (r < 6) k = 4'(1 << $urandom_range(0, 3));
        else if (r < 8) k = 4'd0;
        else k = 4'($urandom_range(0, 15));
        hold_n = $urandom_range(1, 25);
      end
      hold_n--;
      if ($urandom_range(0, 5) == 0) a = ~a;
      step(k, a, ($urandom_range(0, 40) != 0), ($urandom_range(0, 399) == 0));
    end
    idle(2);

    @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d entries left want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/grid_cursor_ctrl.md
GRID_CURSOR_CTRL -- requirements
Module: grid_cursor_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 6, meaning grid columns (>=2).
REQ-002 SHALL have parameter ROWS, default 6, meaning grid rows (>=2).
REQ-003 SHALL have parameter REPEAT_DELAY, default 8, meaning cycles from first move to first auto-repeat move (>=1).
REQ-004 SHALL have parameter REPEAT_RATE, default 4, meaning cycles between later auto-repeat moves (>=1).
REQ-005 SHALL have port: clock  input  1  single system clock; all logic on rising edge.
REQ-006 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port: keys  input  4  active-high; bit0 up, bit1 down, bit2 left, bit3 right.
REQ-008 SHALL have port: A  input  1  active-high select button.
REQ-009 SHALL have port: enable  input  1  high = cursor active (game/select state).
REQ-010 SHALL have port: row  output  $clog2(ROWS)  cursor row, 0 = top.
REQ-011 SHALL have port: col  output  $clog2(COLS)  cursor column, 0 = left.
REQ-012 SHALL have port: pos  output  $clog2(ROWS*COLS)  linear index, row*COLS+col.
REQ-013 SHALL have port: moved  output  1  one-cycle pulse when row/col changed.
REQ-014 SHALL have port: select  output  1  one-cycle pulse on A press.

Function
REQ-015 SHALL register keys and A into keys_q/A_q each edge; all decisions use the registered copies, so input asserted before edge n affects outputs at edge n+1.
REQ-016 SHALL treat keys_q as a valid direction only when exactly one bit is set; zero or multiple bits = no key.
REQ-017 SHALL implement FSM IDLE, HOLD, REPEAT with one counter cnt.
REQ-018 IDLE: valid key -> move once, cnt=0, go HOLD; no key -> stay.
REQ-019 HOLD: same key held -> cnt++; when cnt reaches REPEAT_DELAY-1, move, cnt=0, go REPEAT.
REQ-020 REPEAT: same key held -> cnt++; when cnt reaches REPEAT_RATE-1, move, cnt=0.
REQ-021 HOLD/REPEAT: no key -> IDLE, no move; different valid key -> treat as new press (move immediately, cnt=0, HOLD).
REQ-022 Move: up row-1, down row+1, left col-1, right col+1; pos recomputed in same cycle as row/col.
REQ-023 moved SHALL be high exactly the cycle after row/col changed value; an attempted move that leaves position unchanged SHALL NOT pulse moved.
REQ-024 select SHALL pulse one cycle when A_q rises (A_q=1, previous A_q=0) and enable=1; holding A gives one pulse.
REQ-025 enable=0 SHALL force IDLE, cnt=0, hold row/col/pos, suppress moved and select.
REQ-026 Simultaneous move and select in a cycle SHALL both occur; select reports the pre-move position is not required, pos updates normally.

Reset
REQ-027 On reset: row=0, col=0, pos=0, moved=0, select=0, state IDLE, cnt=0, keys_q=0, A_q=0.
REQ-028 Reset mid-HOLD/REPEAT SHALL abort the sequence; a key still held after reset release is treated as a new press.

Configuration
REQ-029 Macro CURSOR_WRAP_EN defined: move past an edge wraps (left at col 0 -> COLS-1, right at COLS-1 -> 0, up at row 0 -> ROWS-1, down at ROWS-1 -> 0; row unchanged on column wrap and vice versa), moved pulses.
REQ-030 Macro CURSOR_WRAP_EN undefined: move past an edge clamps; position unchanged, no moved pulse; FSM timing unchanged.

Verification (defaults 6x6, DELAY 8, RATE 4)
REQ-031 reset high 2 cycles -> row=0, col=0, pos=0, moved=0, select=0.
REQ-032 enable=1, keys=4'b1000 for 1 cycle from (0,0) -> col=1, pos=1 two edges after assertion, moved high 1 cycle, no further moves.
REQ-033 keys=4'b1000 held 20 cycles from (0,0) -> moves at cycles t, t+8, t+12, t+16 -> col=4, pos=4.
REQ-034 keys=4'b0100 at (2,0) -> with CURSOR_WRAP_EN col=5, pos=17, moved pulse; without it col=0, pos=12, moved=0.
REQ-035 keys=4'b1001 held 10 cycles -> no move; then A high 5 cycles -> exactly one select pulse, pos unchanged.
REQ-036 keys=4'b0010 held, enable dropped after first move -> no further moves; re-enable then reset mid-REPEAT -> pos=0 next edge, new press movement after release of reset.
